keypad_scanner: RTL and testbench

Upstream stage of the keypad debouncer. It drives the 4x4 matrix keypad columns one at a time (active-low) and synchronizes the asynchronous active-low row inputs. When any row is active, it stops on that column and presents a clean active-high row vector plus the decoded hex key code to the debouncer. It stays on that column until the key is released and the debouncer no longer holds it.

---
 rtl/keypad_scanner.sv | 160 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning front end for a 4x4 active-low keypad.
// Drives one column low at a time and waits a settle period on it. When a
// row answers, the scanner locks onto that column and streams the
// synchronized rows to the debouncer. It moves on only after the rows have
// been quiet for a full settle period and the debouncer has dropped hold.
module keypad_scanner #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  input  logic       hold,
  output logic [3:0] cols_n,
  output logic [3:0] q_row_keys,
  output logic [3:0] hex_R_out,
  output logic       key_valid,
  output logic       multi_key
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  // Last dwell count in SCAN; the sample of act is taken on this count.
  localparam logic [CW-1:0] DWELL_LAST = CW'(SETTLE_CYCLES - 1);
  // The LOCK->RELEASE edge already consumed one quiet cycle, so the
  // RELEASE count reaches SETTLE_CYCLES quiet samples at SETTLE_CYCLES-2.
  localparam logic [CW-1:0] QUIET_LAST = CW'(SETTLE_CYCLES - 2);

  typedef enum logic [1:0] {SCAN, LOCK, RELEASE} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [1:0]  col_idx;
  logic [3:0]  sync_q1, sync_q2;
  logic [3:0]  act;
  logic [1:0]  lo_row;
  logic        act_multi;
  logic [1:0]  col_next;

  // Two-flop synchronizer; idle rows are pulled up so reset to all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 4'b1111;
      sync_q2 <= 4'b1111;
    end else begin
      sync_q1 <= rows_n;
      sync_q2 <= sync_q1;
    end
  end

  assign act       = ~sync_q2;
  assign act_multi = (act & (act - 4'd1)) != 4'd0;
  assign col_next  = col_idx + 2'd1;

  // Lowest active row wins the decode when several rows share the column.
  always_comb begin
    lo_row = 2'd0;
    if (act[0])      lo_row = 2'd0;
    else if (act[1]) lo_row = 2'd1;
    else if (act[2]) lo_row = 2'd2;
    else if (act[3]) lo_row = 2'd3;
  end

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  // Scan / lock / release controller with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SCAN;
      cnt        <= '0;
      col_idx    <= 2'd0;
      cols_n     <= 4'b1110;
      q_row_keys <= 4'd0;
      hex_R_out  <= 4'd0;
      key_valid  <= 1'b0;
      multi_key  <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          q_row_keys <= 4'd0;
          key_valid  <= 1'b0;
          multi_key  <= 1'b0;
          if (cnt == DWELL_LAST) begin
            cnt <= '0;
            if (act != 4'd0) begin
              state      <= LOCK;
              q_row_keys <= act;
              hex_R_out  <= key_code(lo_row, col_idx);
              key_valid  <= 1'b1;
              multi_key  <= act_multi;
            end else begin
              col_idx <= col_next;
              cols_n  <= col_drive(col_next);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOCK: begin
          q_row_keys <= act;
          multi_key  <= act_multi;
          key_valid  <= 1'b1;
          if (act == 4'd0) begin
            state <= RELEASE;
            cnt   <= '0;
          end
        end
        RELEASE: begin
          q_row_keys <= act;
          if (act != 4'd0) begin
            // Bounce: back to LOCK with the original code kept.
            state     <= LOCK;
            multi_key <= act_multi;
          end else if (cnt >= QUIET_LAST) begin
            if (!hold) begin
              state      <= SCAN;
              cnt        <= '0;
              col_idx    <= col_next;
              cols_n     <= col_drive(col_next);
              key_valid  <= 1'b0;
              multi_key  <= 1'b0;
              q_row_keys <= 4'd0;
            end
            // With hold high the count simply stays saturated.
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SETTLE_CYCLES=4. A small keypad
// model pulls a row low only while its column is driven, so timing through
// the scan follows from the column the DUT actually drives.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows_n;
  logic       hold;
  logic [3:0] cols_n, q_row_keys, hex_R_out;
  logic       key_valid, multi_key;

  logic [3:0] keys [4];   // keys[row][col] = pressed
  int nvec = 0;
  int nerr = 0;

  keypad_scanner #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .rows_n(rows_n), .hold(hold),
    .cols_n(cols_n), .q_row_keys(q_row_keys), .hex_R_out(hex_R_out),
    .key_valid(key_valid), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Keypad matrix: row r is low when any pressed key on it sits on the driven column.
  always_comb begin
    rows_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      rows_n[r] = ~|(keys[r] & ~cols_n);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [3:0] exp_q [8];
  int n;

  initial begin
    for (int r = 0; r < 4; r++) keys[r] = 4'd0;
    hold  = 1'b0;
    reset = 1'b1;
    step(); step();
    chk("rst_cols", cols_n, 4'b1110);
    chk("rst_q",    q_row_keys, 4'd0);
    chk("rst_hex",  hex_R_out, 4'd0);
    chk("rst_vld",  key_valid, 1'b0);
    chk("rst_multi", multi_key, 1'b0);
    reset = 1'b0;

    // Idle scan: 4 cycles per column, rotating through all four.
    for (int k = 1; k <= 40; k++) begin
      step();
      chk($sformatf("idle_cols_%0d", k), cols_n, 32'(~(4'b0001 << ((k / 4) % 4)) & 4'hF));
      chk("idle_q",   q_row_keys, 4'd0);
      chk("idle_vld", key_valid, 1'b0);
    end

    // Column 2 just became active; press row1/col2 ("6").
    keys[1][2] = 1'b1;
    step(); step(); step();
    chk("pre_sample_vld", key_valid, 1'b0);
    chk("pre_sample_q",   q_row_keys, 4'd0);
    step();
    chk("lock_vld",   key_valid, 1'b1);
    chk("lock_q",     q_row_keys, 4'b0010);
    chk("lock_hex",   hex_R_out, 4'h6);
    chk("lock_cols",  cols_n, 4'b1011);
    chk("lock_multi", multi_key, 1'b0);

    // Bounce: raw off, on, off; q lags the raw pin by 3 edges.
    exp_q = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    keys[1][2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) keys[1][2] = 1'b1;
      if (i == 1) keys[1][2] = 1'b0;
      chk($sformatf("bounce_q_%0d", i), q_row_keys, exp_q[i]);
      if (i < 7) begin
        chk($sformatf("bounce_vld_%0d", i), key_valid, 1'b1);
        chk($sformatf("bounce_hex_%0d", i), hex_R_out, 4'h6);
        chk($sformatf("bounce_cols_%0d", i), cols_n, 4'b1011);
      end else begin
        chk("release_vld",  key_valid, 1'b0);
        chk("release_cols", cols_n, 4'b0111);
      end
    end

    // Hold: lock "C" on column 3, release under hold for 20 cycles.
    keys[2][3] = 1'b1;
    step(); step(); step(); step();
    chk("hold_lock_vld", key_valid, 1'b1);
    chk("hold_lock_hex", hex_R_out, 4'hC);
    hold = 1'b1;
    keys[2][3] = 1'b0;
    for (int i = 0; i < 19; i++) begin
      step();
      chk($sformatf("hold_cols_%0d", i), cols_n, 4'b0111);
      chk($sformatf("hold_vld_%0d", i), key_valid, 1'b1);
    end
    step();
    chk("hold_last_vld", key_valid, 1'b1);
    hold = 1'b0;
    step();
    chk("unhold_vld",  key_valid, 1'b0);
    chk("unhold_cols", cols_n, 4'b1110);
    chk("unhold_q",    q_row_keys, 4'd0);

    // Multi-key on column 3: rows 0 and 3; reached 16 cycles later.
    keys[0][3] = 1'b1;
    keys[3][3] = 1'b1;
    n = 0;
    while (!key_valid && n < 40) begin
      step();
      n++;
    end
    chk("multi_latency", n, 16);
    chk("multi_q",     q_row_keys, 4'b1001);
    chk("multi_hex",   hex_R_out, 4'hA);
    chk("multi_flag",  multi_key, 1'b1);
    chk("multi_cols",  cols_n, 4'b0111);

    // Asynchronous reset while locked, checked before any clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk("async_cols",  cols_n, 4'b1110);
    chk("async_vld",   key_valid, 1'b0);
    chk("async_hex",   hex_R_out, 4'd0);
    chk("async_q",     q_row_keys, 4'd0);
    chk("async_multi", multi_key, 1'b0);
    step();
    reset = 1'b0;
    for (int r = 0; r < 4; r++) keys[r] = 4'd0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
